// File: rtl/phase_lock_detector_if.sv
// Reference/feedback inputs and lock-status outputs of the lock detector.
interface phase_lock_detector_if #(
  parameter int CNT_WIDTH = 20
);
  logic                 refIn;
  logic                 fbIn;
  logic                 locked;
  logic [1:0]           lockState;
  logic [CNT_WIDTH-1:0] refPeriod;
  logic [CNT_WIDTH-1:0] phaseErr;
  logic                 evalValid;
  logic                 refLost;

  modport master (
    output refIn, fbIn,
    input  locked, lockState, refPeriod,
    input  phaseErr, evalValid, refLost
  );

  modport slave (
    input  refIn, fbIn,
    output locked, lockState, refPeriod,
    output phaseErr, evalValid, refLost
  );
endinterface

// File: rtl/phase_lock_detector.sv
// Measures reference period and ref-to-feedback phase, judges each period,
// and runs a hysteretic lock FSM over those judgements.
module phase_lock_detector #(
  parameter int CNT_WIDTH    = 20,
  parameter int WINDOW       = 4,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4
) (
  input logic                  clk,
  input logic                  reset,
  phase_lock_detector_if.slave bus
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] WIN = CNT_WIDTH'(WINDOW);
  localparam logic [GW-1:0] GMAX = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] BMAX = BW'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    ACQUIRING = 2'd1,
    LOCKED    = 2'd2,
    LOSING    = 2'd3
  } state_t;

  logic [2:0]           r_ref_sync;
  logic [2:0]           r_fb_sync;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_phase;
  logic [CNT_WIDTH-1:0] r_period;
  logic [CNT_WIDTH-1:0] r_phase_err;
  logic                 r_fb_seen;
  logic                 r_fb_multi;
  logic                 r_primed;
  logic                 r_eval;
  logic                 r_lost;
  state_t               r_state;
  logic [GW-1:0]        r_good_cnt;
  logic [BW-1:0]        r_bad_cnt;

  logic                 w_ref_p;
  logic                 w_fb_p;
  logic                 w_sat;
  logic                 w_timeout;
  logic                 w_eval;
  logic                 w_good;
  logic [CNT_WIDTH-1:0] w_inc;
  logic [CNT_WIDTH-1:0] w_lo;
  logic [GW-1:0]        w_good_inc;
  logic [BW-1:0]        w_bad_inc;
  state_t               w_state_nx;
  logic [GW-1:0]        w_good_nx;
  logic [BW-1:0]        w_bad_nx;

  // Bit 0/1 synchronize, bit 2 holds the previous level for edge detection.
  assign w_ref_p    = r_ref_sync[1] & ~r_ref_sync[2];
  assign w_fb_p     = r_fb_sync[1] & ~r_fb_sync[2];
  assign w_sat      = &r_cnt;
  assign w_inc      = w_sat ? r_cnt : r_cnt + 1'b1;
  assign w_timeout  = w_sat & ~w_ref_p;
  assign w_eval     = w_ref_p & r_primed;
  assign w_lo       = (w_inc > WIN) ? w_inc - WIN : '0;
  assign w_good     = r_fb_seen & ~r_fb_multi &
                      ((r_phase <= WIN) | (r_phase >= w_lo));
  assign w_good_inc = r_good_cnt + 1'b1;
  assign w_bad_inc  = r_bad_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref_sync  <= '0;
      r_fb_sync   <= '0;
      r_cnt       <= '0;
      r_phase     <= '0;
      r_period    <= '0;
      r_phase_err <= '0;
      r_fb_seen   <= 1'b0;
      r_fb_multi  <= 1'b0;
      r_primed    <= 1'b0;
      r_eval      <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_ref_sync <= {r_ref_sync[1:0], bus.refIn};
      r_fb_sync  <= {r_fb_sync[1:0], bus.fbIn};
      r_cnt      <= w_ref_p ? '0 : w_inc;
      r_eval     <= w_eval;
      if (w_eval) r_phase_err <= r_phase;
      if (w_ref_p) begin
        // A coincident fb edge opens the new period at phase 0.
        r_period   <= w_inc;
        r_primed   <= 1'b1;
        r_lost     <= 1'b0;
        r_phase    <= '0;
        r_fb_seen  <= w_fb_p;
        r_fb_multi <= 1'b0;
      end else begin
        if (w_timeout) begin
          r_primed <= 1'b0;
          r_lost   <= 1'b1;
        end
        if (w_fb_p) begin
          if (r_fb_seen) begin
            r_fb_multi <= 1'b1;
          end else begin
            r_phase   <= w_inc;
            r_fb_seen <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= UNLOCKED;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_good_cnt <= w_good_nx;
      r_bad_cnt  <= w_bad_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_good_nx  = r_good_cnt;
    w_bad_nx   = r_bad_cnt;
    if (w_timeout) begin
      w_state_nx = UNLOCKED;
      w_good_nx  = '0;
      w_bad_nx   = '0;
    end else if (w_eval) begin
      unique case (r_state)
        UNLOCKED: begin
          if (w_good) begin
            w_state_nx = ACQUIRING;
            w_good_nx  = GW'(1);
          end
        end
        ACQUIRING: begin
          if (!w_good) begin
            w_state_nx = UNLOCKED;
            w_good_nx  = '0;
          end else if (w_good_inc == GMAX) begin
            w_state_nx = LOCKED;
            w_good_nx  = '0;
          end else begin
            w_good_nx = w_good_inc;
          end
        end
        LOCKED: begin
          if (!w_good) begin
            w_state_nx = LOSING;
            w_bad_nx   = BW'(1);
          end
        end
        LOSING: begin
          if (w_good) begin
            w_state_nx = LOCKED;
            w_bad_nx   = '0;
          end else if (w_bad_inc == BMAX) begin
            w_state_nx = UNLOCKED;
            w_bad_nx   = '0;
          end else begin
            w_bad_nx = w_bad_inc;
          end
        end
        default: w_state_nx = UNLOCKED;
      endcase
    end
  end

  assign bus.locked    = r_state[1];
  assign bus.lockState = r_state;
  assign bus.refPeriod = r_period;
  assign bus.phaseErr  = r_phase_err;
  assign bus.evalValid = r_eval;
  assign bus.refLost   = r_lost;
endmodule

// File: tb/tb_phase_lock_detector.sv
// Bench for phase_lock_detector: directed scenarios plus random periods,
// checked every cycle against an edge-time reference model.
module tb_phase_lock_detector;
  localparam int W    = 10;
  localparam int MAXV = (1 << W) - 1;
  localparam int LIM  = 1 << W;
  localparam int WIN  = 4;
  localparam int LC   = 16;
  localparam int UC   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  phase_lock_detector_if #(.CNT_WIDTH(W)) pif ();

  phase_lock_detector #(
    .CNT_WIDTH(W),
    .WINDOW(WIN),
    .LOCK_COUNT(LC),
    .UNLOCK_COUNT(UC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(pif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int eval_seen = 0;

  // Model state: edge index, edge of last ref event, fb events this period.
  int m_e = 0;
  int m_r = 0;
  int m_nfb = 0;
  int m_ph = 0;
  bit m_primed = 0;
  bit m_lost = 0;
  int m_st = 0;
  int m_gc = 0;
  int m_bc = 0;
  int m_period = 0;
  int m_phase = 0;
  bit m_eval = 0;
  bit m_pr = 0;
  bit m_pf = 0;
  int rq[$];
  int fq[$];

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_judgement(bit good);
    case (m_st)
      0: if (good) begin m_st = 1; m_gc = 1; end
      1: begin
        if (!good) begin
          m_st = 0; m_gc = 0;
        end else begin
          m_gc++;
          if (m_gc == LC) begin m_st = 2; m_gc = 0; end
        end
      end
      2: if (!good) begin m_st = 3; m_bc = 1; end
      default: begin
        if (good) begin
          m_st = 2; m_bc = 0;
        end else begin
          m_bc++;
          if (m_bc == UC) begin m_st = 0; m_bc = 0; end
        end
      end
    endcase
  endtask

  task automatic model_step();
    int el;
    int cap;
    int lo;
    bit rev;
    bit fev;
    bit good;
    m_e++;
    if (reset) begin
      m_r = m_e; m_nfb = 0; m_ph = 0; m_primed = 0; m_lost = 0;
      m_st = 0; m_gc = 0; m_bc = 0; m_period = 0; m_phase = 0;
      m_eval = 0; m_pr = 0; m_pf = 0;
      rq.delete(); fq.delete();
      return;
    end
    // An input edge sampled at edge c takes effect at edge c+2.
    if (pif.refIn && !m_pr) rq.push_back(m_e + 2);
    if (pif.fbIn && !m_pf) fq.push_back(m_e + 2);
    m_pr = pif.refIn;
    m_pf = pif.fbIn;
    rev = 0;
    fev = 0;
    if (rq.size() > 0 && rq[0] == m_e) begin
      rev = 1; void'(rq.pop_front());
    end
    if (fq.size() > 0 && fq[0] == m_e) begin
      fev = 1; void'(fq.pop_front());
    end
    el = m_e - m_r;
    cap = (el > MAXV) ? MAXV : el;
    m_eval = 0;
    if (rev) begin
      if (m_primed) begin
        lo = (cap > WIN) ? cap - WIN : 0;
        good = (m_nfb == 1) && (m_ph <= WIN || m_ph >= lo);
        m_eval = 1;
        m_phase = m_ph;
        apply_judgement(good);
      end
      m_period = cap;
      m_primed = 1;
      m_lost = 0;
      m_r = m_e;
      m_nfb = fev ? 1 : 0;
      m_ph = 0;
    end else begin
      if (fev) begin
        if (m_nfb == 0) m_ph = cap;
        m_nfb++;
      end
      if (el >= LIM) begin
        m_lost = 1; m_primed = 0; m_st = 0; m_gc = 0; m_bc = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [31:0] act;
    logic [31:0] expv;
    @(negedge clk);
    if (!reset) begin
      act = {7'd0, pif.locked, pif.lockState, pif.evalValid,
             pif.refLost, pif.refPeriod, pif.phaseErr};
      expv = {7'd0, (m_st >= 2), 2'(m_st), m_eval, m_lost,
              W'(m_period), W'(m_phase)};
      if (pif.evalValid === 1'b1) eval_seen++;
      n_chk++;
      if (act !== expv) begin
        n_fail++;
        $display("FAIL cycle %0d outputs got %h expected %h",
                 m_e, act, expv);
        if (n_fail >= 100) finish_run();
      end
    end
  end

  task automatic drive(int per, int off, bit fb_en, bit dbl, int ncyc);
    int pos;
    int d;
    pos = ((off % per) + per) % per;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      d = (k - pos + per) % per;
      pif.refIn = (k < per / 2);
      pif.fbIn = fb_en && (d < 4 || (dbl && d >= 64 && d < 68));
    end
  endtask

  task automatic periods(int n, int per, int off, bit fb_en);
    repeat (n) drive(per, off, fb_en, 1'b0, per);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    reset = 1'b1;
    pif.refIn = 1'b0;
    pif.fbIn = 1'b0;
    #1;
    lit({tag, "_locked"}, pif.locked, 0);
    lit({tag, "_lockState"}, pif.lockState, 0);
    lit({tag, "_refPeriod"}, pif.refPeriod, 0);
    lit({tag, "_phaseErr"}, pif.phaseErr, 0);
    lit({tag, "_evalValid"}, pif.evalValid, 0);
    lit({tag, "_refLost"}, pif.refLost, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int e0;
    int per;
    int off;
    bit fb_en;
    bit dbl;
    pif.refIn = 1'b0;
    pif.fbIn = 1'b0;
    do_reset("rst0");

    periods(16, 256, 0, 1);
    lit("pair_acq_15", pif.lockState, 1);
    periods(1, 256, 0, 1);
    lit("pair_state", pif.lockState, 2);
    lit("pair_locked", pif.locked, 1);
    lit("pair_period", pif.refPeriod, 256);
    lit("pair_phase", pif.phaseErr, 0);

    do_reset("rst1");
    periods(17, 256, 4, 1);
    lit("lag4_state", pif.lockState, 2);
    lit("lag4_phase", pif.phaseErr, 4);
    periods(20, 256, 5, 1);
    lit("lag5_state", pif.lockState, 0);
    lit("lag5_phase", pif.phaseErr, 5);
    periods(20, 256, -4, 1);
    lit("lead4_state", pif.lockState, 2);
    lit("lead4_phase", pif.phaseErr, 252);

    periods(3, 256, -4, 0);
    periods(1, 256, -4, 1);
    lit("hyst3_state", pif.lockState, 3);
    lit("hyst3_locked", pif.locked, 1);
    periods(1, 256, -4, 1);
    lit("hyst_back", pif.lockState, 2);
    periods(4, 256, -4, 0);
    periods(1, 256, -4, 1);
    lit("hyst4_state", pif.lockState, 0);
    lit("hyst4_locked", pif.locked, 0);

    do_reset("rst2");
    periods(10, 256, 0, 1);
    drive(256, 0, 1, 1, 256);
    lit("dbl_acq10", pif.lockState, 1);
    periods(1, 256, 0, 1);
    lit("dbl_state", pif.lockState, 0);

    periods(17, 256, 0, 1);
    lit("loss_pre", pif.lockState, 2);
    repeat (1100) begin
      @(negedge clk);
      pif.refIn = 1'b0;
      pif.fbIn = 1'b0;
    end
    lit("loss_refLost", pif.refLost, 1);
    lit("loss_state", pif.lockState, 0);
    e0 = eval_seen;
    periods(1, 256, 0, 1);
    lit("loss_clear", pif.refLost, 0);
    lit("loss_sat_period", pif.refPeriod, MAXV);
    lit("loss_no_eval", eval_seen, e0);
    periods(1, 256, 0, 1);
    lit("loss_next_eval", eval_seen, e0 + 1);

    periods(16, 256, 0, 1);
    lit("arst_pre", pif.lockState, 2);
    drive(256, 0, 1, 0, 100);
    do_reset("arst");
    periods(16, 256, 0, 1);
    lit("relock_16", pif.lockState, 1);
    periods(1, 256, 0, 1);
    lit("relock_17", pif.lockState, 2);

    for (int i = 0; i < 80; i++) begin
      per = int'($urandom_range(300, 40));
      off = int'($urandom_range(12)) - 6;
      fb_en = ($urandom_range(9) != 0);
      dbl = (per >= 100) && ($urandom_range(19) == 0);
      drive(per, off, fb_en, dbl, per);
    end

    repeat (4) @(negedge clk);
    finish_run();
  end
endmodule

// File: doc/phase_lock_detector.md
Name: phase_lock_detector

Overview:
- Monitors the recovered-clock loop by comparing the reference input against the DPLL's divided feedback output, both sampled on the fast oscillator clock.
- Measures the reference period and the reference-to-feedback phase offset, and judges each reference period good or bad.
- A hysteretic FSM turns those judgements into a lock indication, consumed by the top level and by debug outputs.

Parameters:
- CNT_WIDTH, 20: width of period/phase counters and measurement outputs.
- WINDOW, 4: max phase offset in clk cycles, either side of the reference edge, counted as aligned.
- LOCK_COUNT, 16: consecutive good periods needed to declare lock.
- UNLOCK_COUNT, 4: consecutive bad periods needed to drop lock.

Ports:
- clk  input  1  oscillator clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- refIn  input  1  reference clock; asynchronous to clk.
- fbIn  input  1  DPLL feedback (divided output); asynchronous to clk.
- locked  output  1  high in LOCKED and LOSING states.
- lockState  output  2  0=UNLOCKED, 1=ACQUIRING, 2=LOCKED, 3=LOSING.
- refPeriod  output  CNT_WIDTH  last measured reference period in clk cycles.
- phaseErr  output  CNT_WIDTH  clk cycles from reference edge to first feedback edge in the last evaluated period.
- evalValid  output  1  one-cycle pulse when a period evaluation is made.
- refLost  output  1  high while the reference is missing (timeout).

Behaviour:
- Reset: all outputs 0, FSM in UNLOCKED, counters 0, primed=0.
- Input path:
  - refIn and fbIn each pass a 2-flop synchronizer, then a rising-edge detector (third flop).
  - An input rising edge produces an internal one-cycle pulse 3 clk later.
- Period counter:
  - Increments every clk and saturates at all-ones.
  - On a ref pulse it is latched into refPeriod (count+1) and restarted at 0.
- Feedback capture:
  - First fb pulse after a ref pulse latches the current counter value as phase and sets fbSeen.
  - A further fb pulse in the same period sets fbMulti.
  - An fb pulse in the same cycle as a ref pulse belongs to the new period, with phase=0.
- Evaluation, on each ref pulse when primed=1:
  - good = fbSeen & ~fbMulti & (phase <= WINDOW or phase >= refPeriod-WINDOW). Subtraction saturates at 0.
  - phaseErr is updated, and evalValid pulses 1 cycle after the ref pulse.
  - fbSeen and fbMulti are then cleared for the new period, except for a coincident fb pulse.
- First ref pulse after reset or after timeout: sets primed=1 only. No evaluation, no evalValid.
- FSM (good/bad events come only from evaluations):
  - UNLOCKED: good -> ACQUIRING with goodCnt=1.
  - ACQUIRING: good increments goodCnt; at goodCnt==LOCK_COUNT go to LOCKED. Bad -> UNLOCKED with goodCnt=0.
  - LOCKED: bad -> LOSING with badCnt=1; good stays.
  - LOSING: good -> LOCKED with badCnt=0. Bad increments badCnt; at badCnt==UNLOCK_COUNT go to UNLOCKED.
  - lockState and locked change in the same cycle as evalValid.
- Timeout: when the period counter saturates:
  - refLost=1, FSM forced to UNLOCKED, primed=0, goodCnt and badCnt cleared.
  - refLost clears on the next ref pulse.
- Reset asserted mid-operation immediately returns everything to reset values, including synchronizer flops.

Test Plan:
- Locked pair: ref and fb identical, period 256 clk -> after 1 priming edge and 16 evaluations locked=1, lockState=2; phaseErr=0, refPeriod=256 throughout.
- Offset tolerance: fb lags ref by 4 clk -> locks after 16 evaluations. Lag 5 clk -> every evaluation bad, stays UNLOCKED. Lead of 4 clk (phase=252 at period 256) -> good.
- Hysteresis: from LOCKED, remove fb for 3 periods -> lockState=3 with locked=1, then 1 good period returns to 2. Remove fb for 4 periods -> lockState=0, locked=0.
- Double edge: two fb edges within one ref period while ACQUIRING with goodCnt=10 -> lockState=0, goodCnt cleared.
- Reference loss: from LOCKED, hold refIn low -> after 2^20-1 clk refLost=1, lockState=0. Next ref edge clears refLost with no evalValid; the following edge evaluates.
- Async reset pulse asserted mid-period while LOCKED -> all outputs 0 in the same cycle. Re-lock requires 1+16 ref edges.
